// File: rtl/sprite_pal_pkg.sv
// sprite_pal_pkg: shared types and the power-on palette for sprite_palette_bank.
// Revision: 1.0
`default_nettype none

package sprite_pal_pkg;

  localparam int DEF_CH_W = 4;

  typedef struct packed {
    logic [DEF_CH_W-1:0] r;
    logic [DEF_CH_W-1:0] g;
    logic [DEF_CH_W-1:0] b;
  } rgb_t;

  typedef enum logic [0:0] {
    FL_IDLE  = 1'b0,
    FL_FLASH = 1'b1
  } flash_state_e;

  localparam rgb_t DEF_PAL [8] = '{
    rgb_t'(12'h631), rgb_t'(12'h0E0), rgb_t'(12'h05E), rgb_t'(12'hEBA),
    rgb_t'(12'h000), rgb_t'(12'h070), rgb_t'(12'hE30), rgb_t'(12'h028)
  };

  // Entries beyond the eight-colour table come up black.
  function automatic logic [11:0] def_entry(input int e);
    logic [11:0] v;
    v = 12'h000;
    if (e >= 0 && e < 8) v = DEF_PAL[e[2:0]];
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pal_flash_fsm.sv
// pal_flash_fsm: frame-counted hit-flash sequencer producing the white_on strobe.
// Revision: 1.0
`default_nettype none

module pal_flash_fsm
  import sprite_pal_pkg::*;
#(
  parameter int FLASH_FRAMES = 16,
  parameter int FLASH_PERIOD = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_tick,
  input  logic flash_start,
  output logic white_on,
  output logic flashing
);

  localparam int FC_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int PC_W = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
  localparam logic [FC_W-1:0] FRAME_LAST = FC_W'(FLASH_FRAMES - 1);
  localparam logic [PC_W-1:0] PHASE_LAST = PC_W'(FLASH_PERIOD - 1);

  flash_state_e    state, state_nx;
  logic [FC_W-1:0] frame_cnt, frame_cnt_nx;
  logic [PC_W-1:0] phase_cnt, phase_cnt_nx;
  logic            white_q, white_nx;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= FL_IDLE;
      frame_cnt <= '0;
      phase_cnt <= '0;
      white_q   <= 1'b0;
    end else begin
      state     <= state_nx;
      frame_cnt <= frame_cnt_nx;
      phase_cnt <= phase_cnt_nx;
      white_q   <= white_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    frame_cnt_nx = frame_cnt;
    phase_cnt_nx = phase_cnt;
    white_nx     = white_q;
    case (state)
      FL_IDLE: begin
        if (flash_start) begin
          state_nx     = FL_FLASH;
          frame_cnt_nx = '0;
          phase_cnt_nx = '0;
          white_nx     = 1'b1;
        end
      end
      FL_FLASH: begin
        // A restart wins over a tick landing in the same cycle.
        if (flash_start) begin
          frame_cnt_nx = '0;
          phase_cnt_nx = '0;
          white_nx     = 1'b1;
        end else if (frame_tick) begin
          if (frame_cnt == FRAME_LAST) begin
            state_nx     = FL_IDLE;
            frame_cnt_nx = '0;
            phase_cnt_nx = '0;
            white_nx     = 1'b0;
          end else begin
            frame_cnt_nx = frame_cnt + FC_W'(1);
            if (phase_cnt == PHASE_LAST) begin
              phase_cnt_nx = '0;
              white_nx     = ~white_q;
            end else begin
              phase_cnt_nx = phase_cnt + PC_W'(1);
            end
          end
        end
      end
      default: state_nx = FL_IDLE;
    endcase
  end

  assign white_on = white_q;
  assign flashing = (state == FL_FLASH);

endmodule

`default_nettype wire

// File: rtl/sprite_palette_bank.sv
// sprite_palette_bank: banked, runtime-writable sprite palette with transparency and hit flash.
// Revision: 1.0
`default_nettype none

module sprite_palette_bank
  import sprite_pal_pkg::*;
#(
  parameter int IDX_W        = 3,
  parameter int NUM_BANKS    = 4,
  parameter int CH_W         = 4,
  parameter int TRANSP_IDX   = 0,
  parameter int FLASH_FRAMES = 16,
  parameter int FLASH_PERIOD = 2,
  localparam int BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_tick,
  input  logic              pix_valid,
  input  logic [BANK_W-1:0] bank_sel,
  input  logic [IDX_W-1:0]  index,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [3*CH_W-1:0] wr_rgb,
  input  logic              flash_start,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic              out_valid,
  output logic              pix_opaque,
  output logic              flashing
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int RGB_W   = 3 * CH_W;

  // Flop array rather than RAM so reset can restore every entry at once.
  logic [RGB_W-1:0] pal [NUM_BANKS][ENTRIES];

  logic             white_on;
  logic             rd_hit;
  logic             wr_hit;
  logic             opaque_d;
  logic [RGB_W-1:0] rd_rgb;
  logic [RGB_W-1:0] lut_rgb;
  logic [RGB_W-1:0] rgb_q;
  logic             opaque_q;
  logic             valid_q;

  // Each 4-bit default nibble sits in the top of a wider channel.
  function automatic logic [RGB_W-1:0] widen(input logic [11:0] v);
    logic [CH_W-1:0] r, g, b;
    r = CH_W'(v[11:8]) << (CH_W - 4);
    g = CH_W'(v[7:4])  << (CH_W - 4);
    b = CH_W'(v[3:0])  << (CH_W - 4);
    return {r, g, b};
  endfunction

  always_ff @(posedge Clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int e = 0; e < ENTRIES; e++) begin
        if (Reset) begin
          pal[b][e] <= widen(def_entry(e));
        end else if (wr_en && wr_bank == BANK_W'(b) && wr_index == IDX_W'(e)) begin
          pal[b][e] <= wr_rgb;
        end
      end
    end
  end

  // A bank_sel with no matching bank leaves rd_hit low: black and transparent.
  always_comb begin
    rd_hit = 1'b0;
    rd_rgb = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int e = 0; e < ENTRIES; e++) begin
        if (bank_sel == BANK_W'(b) && index == IDX_W'(e)) begin
          rd_hit = 1'b1;
          rd_rgb = pal[b][e];
        end
      end
    end
    wr_hit = wr_en && (wr_bank == bank_sel) && (wr_index == index);
    if (rd_hit && wr_hit) rd_rgb = wr_rgb;
    opaque_d = rd_hit && (index != IDX_W'(TRANSP_IDX));
    lut_rgb  = (white_on && opaque_d) ? {RGB_W{1'b1}} : rd_rgb;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rgb_q    <= '0;
      opaque_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= pix_valid;
      if (pix_valid) begin
        rgb_q    <= lut_rgb;
        opaque_q <= opaque_d;
      end
    end
  end

  pal_flash_fsm #(
    .FLASH_FRAMES (FLASH_FRAMES),
    .FLASH_PERIOD (FLASH_PERIOD)
  ) u_flash (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_tick  (frame_tick),
    .flash_start (flash_start),
    .white_on    (white_on),
    .flashing    (flashing)
  );

  assign red        = rgb_q[RGB_W-1 -: CH_W];
  assign green      = rgb_q[2*CH_W-1 -: CH_W];
  assign blue       = rgb_q[CH_W-1 -: CH_W];
  assign out_valid  = valid_q;
  assign pix_opaque = opaque_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_palette_bank.sv
// tb_sprite_palette_bank: randomized self-checking bench against a frame-level palette model.
// Revision: 1.0
`default_nettype none

module tb_sprite_palette_bank;

  localparam int NB = 3;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        pix_valid = 1'b0;
  logic [1:0]  bank_sel = '0;
  logic [2:0]  index = '0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_bank = '0;
  logic [2:0]  wr_index = '0;
  logic [11:0] wr_rgb = '0;
  logic        flash_start = 1'b0;
  logic [3:0]  red, green, blue;
  logic        out_valid, pix_opaque, flashing;

  sprite_palette_bank #(
    .IDX_W(3), .NUM_BANKS(NB), .CH_W(4), .TRANSP_IDX(0), .FLASH_FRAMES(16), .FLASH_PERIOD(2)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .pix_valid(pix_valid),
    .bank_sel(bank_sel), .index(index), .wr_en(wr_en), .wr_bank(wr_bank),
    .wr_index(wr_index), .wr_rgb(wr_rgb), .flash_start(flash_start),
    .red(red), .green(green), .blue(blue), .out_valid(out_valid),
    .pix_opaque(pix_opaque), .flashing(flashing)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: palette contents, flash activity and ticks seen since the flash began.
  logic [11:0] m_pal [NB][8];
  bit          m_active;
  int          m_k;
  logic [11:0] e_rgb;
  bit          e_valid, e_opq, e_flash;

  function automatic logic [11:0] def_val(input int e);
    case (e)
      0: return 12'h631;
      1: return 12'h0E0;
      2: return 12'h05E;
      3: return 12'hEBA;
      4: return 12'h000;
      5: return 12'h070;
      6: return 12'hE30;
      default: return 12'h028;
    endcase
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++)
      for (int e = 0; e < 8; e++) m_pal[b][e] = def_val(e);
    m_active = 0;
    m_k      = 0;
    e_rgb    = 12'h000;
    e_valid  = 0;
    e_opq    = 0;
    e_flash  = 0;
  endtask

  task automatic drive_cycle(input bit rst, input bit tick, input bit fst, input bit pv,
                             input int bsel, input int idx, input bit we, input int wb,
                             input int wi, input logic [11:0] wrgb);
    bit          white;
    logic [11:0] c;
    Reset = rst; frame_tick = tick; flash_start = fst; pix_valid = pv;
    bank_sel = 2'(bsel); index = 3'(idx); wr_en = we; wr_bank = 2'(wb);
    wr_index = 3'(wi); wr_rgb = wrgb;
    white = m_active && (((m_k / 2) % 2) == 0);
    @(posedge Clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      e_valid = pv;
      if (pv) begin
        if (bsel >= NB) begin
          c = 12'h000;
          e_opq = 0;
        end else begin
          c = (we && wb == bsel && wi == idx) ? wrgb : m_pal[bsel][idx];
          e_opq = (idx != 0);
          if (white && e_opq) c = 12'hFFF;
        end
        e_rgb = c;
      end
      if (we && wb < NB) m_pal[wb][wi] = wrgb;
      if (fst) begin
        m_active = 1;
        m_k = 0;
      end else if (tick && m_active) begin
        m_k++;
        if (m_k == 16) begin
          m_active = 0;
          m_k = 0;
        end
      end
    end
    e_flash = m_active;
  endtask

  task automatic read_px(input int b, input int i);
    drive_cycle(0, 0, 0, 1, b, i, 0, 0, 0, 12'h000);
  endtask

  task automatic test_reset();
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000);
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000);
    n_cmp++;
    if ({out_valid, pix_opaque, flashing, red, green, blue} !== 15'h0) begin
      n_bad++;
      $display("FAIL reset: got v=%b o=%b f=%b rgb=%h%h%h want all zero",
               out_valid, pix_opaque, flashing, red, green, blue);
    end
  endtask

  task automatic test_default_table();
    for (int i = 0; i < 8; i++) begin
      read_px(0, i);
      n_cmp++;
      if ({out_valid, pix_opaque, flashing, red, green, blue} !== {1'b1, (i != 0), 1'b0, def_val(i)}) begin
        n_bad++;
        $display("FAIL default_idx%0d: got v=%b o=%b f=%b rgb=%h%h%h want v=1 o=%b f=0 rgb=%h",
                 i, out_valid, pix_opaque, flashing, red, green, blue, (i != 0), def_val(i));
      end
    end
  endtask

  task automatic test_write_bypass();
    drive_cycle(0, 0, 0, 1, 2, 3, 1, 2, 3, 12'hF0F);
    n_cmp++;
    if ({red, green, blue} !== 12'hF0F || {out_valid, pix_opaque} !== 2'b11) begin
      n_bad++;
      $display("FAIL bypass: got rgb=%h%h%h v=%b o=%b want rgb=f0f v=1 o=1",
               red, green, blue, out_valid, pix_opaque);
    end
    for (int k = 0; k < 2; k++) begin
      read_px((k == 0) ? 0 : 2, 3);
      n_cmp++;
      if ({out_valid, pix_opaque, flashing, red, green, blue} !== {e_valid, e_opq, e_flash, e_rgb}) begin
        n_bad++;
        $display("FAIL write_readback%0d: got v=%b o=%b f=%b rgb=%h%h%h want v=%b o=%b f=%b rgb=%h",
                 k, out_valid, pix_opaque, flashing, red, green, blue, e_valid, e_opq, e_flash, e_rgb);
      end
    end
  endtask

  task automatic test_flash();
    drive_cycle(0, 0, 1, 0, 0, 0, 0, 0, 0, 12'h000);
    for (int t = 0; t < 17; t++) begin
      for (int p = 0; p < 2; p++) begin
        read_px($urandom_range(0, NB - 1), (p == 0) ? 0 : $urandom_range(1, 7));
        n_cmp++;
        if ({out_valid, pix_opaque, flashing, red, green, blue} !== {e_valid, e_opq, e_flash, e_rgb}) begin
          n_bad++;
          $display("FAIL flash_t%0d_p%0d: got v=%b o=%b f=%b rgb=%h%h%h want v=%b o=%b f=%b rgb=%h",
                   t, p, out_valid, pix_opaque, flashing, red, green, blue, e_valid, e_opq, e_flash, e_rgb);
        end
      end
      if (t < 16) drive_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 12'h000);
    end
  endtask

  task automatic test_restart();
    drive_cycle(0, 0, 1, 0, 0, 0, 0, 0, 0, 12'h000);
    for (int t = 0; t < 5; t++) drive_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 12'h000);
    // Restart coincides with a tick; the restart must win.
    drive_cycle(0, 1, 1, 0, 0, 0, 0, 0, 0, 12'h000);
    for (int t = 0; t < 17; t++) begin
      read_px($urandom_range(0, NB - 1), $urandom_range(1, 7));
      n_cmp++;
      if ({out_valid, pix_opaque, flashing, red, green, blue} !== {e_valid, e_opq, e_flash, e_rgb}) begin
        n_bad++;
        $display("FAIL restart_t%0d: got v=%b o=%b f=%b rgb=%h%h%h want v=%b o=%b f=%b rgb=%h",
                 t, out_valid, pix_opaque, flashing, red, green, blue, e_valid, e_opq, e_flash, e_rgb);
      end
      if (t < 16) drive_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 12'h000);
    end
  endtask

  task automatic test_reset_mid_flash();
    drive_cycle(0, 0, 0, 0, 0, 0, 1, 1, 1, 12'h123);
    drive_cycle(0, 0, 1, 0, 0, 0, 0, 0, 0, 12'h000);
    for (int t = 0; t < 3; t++) drive_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 12'h000);
    drive_cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, 12'h000);
    n_cmp++;
    if (flashing !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_flash: got flashing=%b want 0", flashing);
    end
    read_px(1, 1);
    n_cmp++;
    if ({out_valid, pix_opaque, flashing, red, green, blue} !== {3'b110, 12'h0E0}) begin
      n_bad++;
      $display("FAIL reset_reload: got v=%b o=%b f=%b rgb=%h%h%h want v=1 o=1 f=0 rgb=0e0",
               out_valid, pix_opaque, flashing, red, green, blue);
    end
  endtask

  task automatic test_out_of_range();
    drive_cycle(0, 0, 0, 1, 3, 2, 1, 3, 2, 12'hABC);
    for (int b = 0; b < 4; b++) begin
      n_cmp++;
      if ({out_valid, pix_opaque, flashing, red, green, blue} !== {e_valid, e_opq, e_flash, e_rgb}) begin
        n_bad++;
        $display("FAIL oob_b%0d: got v=%b o=%b f=%b rgb=%h%h%h want v=%b o=%b f=%b rgb=%h",
                 b, out_valid, pix_opaque, flashing, red, green, blue, e_valid, e_opq, e_flash, e_rgb);
      end
      read_px(b, 2);
    end
    n_cmp++;
    if ({pix_opaque, red, green, blue} !== 13'h0) begin
      n_bad++;
      $display("FAIL oob_read: got o=%b rgb=%h%h%h want o=0 rgb=000", pix_opaque, red, green, blue);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive_cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 3), $urandom_range(0, 7), ($urandom_range(0, 2) == 0),
                  $urandom_range(0, 3), $urandom_range(0, 7), 12'($urandom));
      n_cmp++;
      if ({out_valid, pix_opaque, flashing, red, green, blue} !== {e_valid, e_opq, e_flash, e_rgb}) begin
        n_bad++;
        $display("FAIL random_%0d: got v=%b o=%b f=%b rgb=%h%h%h want v=%b o=%b f=%b rgb=%h",
                 n, out_valid, pix_opaque, flashing, red, green, blue, e_valid, e_opq, e_flash, e_rgb);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_default_table();
    test_write_bypass();
    test_flash();
    test_restart();
    test_reset_mid_flash();
    test_out_of_range();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
